// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x4 active-low key matrix one column at a time, synchronises the
//   row lines, debounces complete scan frames and presents a one-hot key code.
//
// Parameters
//   SCAN_DIV        clk cycles per column slot (>= 4)
//   DEBOUNCE_FRAMES identical consecutive frames needed before onehot moves (>= 1)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   row[3:0]     in   matrix row lines, active-low, asynchronous to clk
//   col[3:0]     out  matrix column drive, active-low, exactly one bit low
//   onehot[15:0] out  debounced key code, bit = row*4 + col, 0 = no key
//   key_pressed  out  one-cycle strobe when onehot takes a new non-zero value
module keypad_scan #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [15:0] onehot,
  output logic        key_pressed
);

  localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STAB_W = (DEBOUNCE_FRAMES > 0) ? $clog2(DEBOUNCE_FRAMES + 1) : 1;
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_FRAMES);

  // A frame is only a valid key code when exactly one key is seen; zero keys
  // and ghosting combinations both collapse to "none".
  function automatic logic [15:0] single_key(input logic [15:0] v);
    return ((v != 16'd0) && ((v & (v - 16'd1)) == 16'd0)) ? v : 16'd0;
  endfunction

  function automatic logic [STAB_W-1:0] sat_inc(input logic [STAB_W-1:0] s);
    return (s >= STAB_MAX) ? STAB_MAX : s + 1'b1;
  endfunction

  logic [3:0]        row_m;
  logic [3:0]        row_s;
  logic [CNT_W-1:0]  div_cnt;
  logic              tick;
  logic [1:0]        cidx;
  logic [15:0]       raw;
  logic [15:0]       frame_vec;
  logic [15:0]       frame_code;
  logic              frame_done;
  logic [15:0]       cand;
  logic [STAB_W-1:0] stab;
  logic [15:0]       cand_next;
  logic [STAB_W-1:0] stab_next;
  logic              take_code;

  // ---- Stage: row synchroniser ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'b1111;
      row_s <= 4'b1111;
    end else begin
      row_m <= row;
      row_s <= row_m;
    end
  end

  // ---- Stage: slot divider and column rotation ----
  assign tick = (div_cnt == DIV_LAST);
  assign col  = ~(4'b0001 << cidx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      cidx    <= 2'd0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) cidx <= cidx + 2'd1;
    end
  end

  // ---- Stage: column sampling ----
  // The column has been driven for a whole slot, so row_s has settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw <= 16'd0;
    end else if (tick) begin
      for (int r = 0; r < 4; r++) raw[{r[1:0], cidx}] <= ~row_s[r];
    end
  end

  // The column-3 bits of the completing frame come straight from this
  // tick's sample, since raw only captures them on the same edge.
  always_comb begin
    frame_vec = raw;
    for (int r = 0; r < 4; r++) frame_vec[{r[1:0], 2'd3}] = ~row_s[r];
  end

  assign frame_code = single_key(frame_vec);
  assign frame_done = tick && (cidx == 2'd3);

  // ---- Stage: frame debounce ----
  always_comb begin
    cand_next = cand;
    stab_next = stab;
    if (frame_code != cand) begin
      cand_next = frame_code;
      stab_next = STAB_W'(1);
    end else begin
      stab_next = sat_inc(stab);
    end
  end

  assign take_code = (stab_next == STAB_MAX) && (cand_next != onehot);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand        <= 16'd0;
      stab        <= '0;
      onehot      <= 16'd0;
      key_pressed <= 1'b0;
    end else begin
      key_pressed <= 1'b0;
      if (frame_done) begin
        cand <= cand_next;
        stab <= stab_next;
        if (take_code) begin
          onehot      <= cand_next;
          key_pressed <= |cand_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] onehot;
  logic        key_pressed;

  logic [15:0] keys;

  int checks;
  int errors;

  // reference model state
  logic [15:0] m_cand;
  int          m_stab;
  logic [15:0] m_onehot;
  logic        m_strobe;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row(row),
    .col(col),
    .onehot(onehot),
    .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix: a row line is pulled low when a pressed key in that row sits on
  // the column currently driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  task automatic model_reset();
    m_cand   = 16'd0;
    m_stab   = 0;
    m_onehot = 16'd0;
    m_strobe = 1'b0;
  endtask

  // One complete frame with a steady key set.
  task automatic model_frame(input logic [15:0] k);
    logic [15:0] code;
    code = ($countones(k) == 1) ? k : 16'd0;
    if (code != m_cand) begin
      m_cand = code;
      m_stab = 1;
    end else if (m_stab < DB) begin
      m_stab = m_stab + 1;
    end
    m_strobe = 1'b0;
    if (m_stab == DB && m_cand != m_onehot) begin
      m_onehot = m_cand;
      m_strobe = (m_cand != 16'd0);
    end
  endtask

  // Holds k for one frame; reports onehot/key_pressed just after the
  // frame-completing edge and how many earlier cycles showed any change.
  task automatic run_frame(input logic [15:0] k, output logic [15:0] oh,
                           output logic kp, output int glitch);
    logic [15:0] start;
    keys   = k;
    start  = onehot;
    glitch = 0;
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      if (i < FRAME && (onehot !== start || key_pressed !== 1'b0)) glitch++;
    end
    oh = onehot;
    kp = key_pressed;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    keys  = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (col !== 4'b1110) begin
      errors++; $display("FAIL reset_col: got %b want 1110", col);
    end
    checks++;
    if (onehot !== 16'd0) begin
      errors++; $display("FAIL reset_onehot: got %h want 0000", onehot);
    end
    checks++;
    if (key_pressed !== 1'b0) begin
      errors++; $display("FAIL reset_kp: got %b want 0", key_pressed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (col !== 4'b1110) begin
      errors++; $display("FAIL release_col: got %b want 1110", col);
    end
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk);
      #1;
      exp_col = ~(4'b0001 << ((i / SD) % 4));
      checks++;
      if (col !== exp_col) begin
        errors++; $display("FAIL col_rotate cycle %0d: got %b want %b", i, col, exp_col);
      end
    end
    model_frame(16'd0);
    checks++;
    if (onehot !== 16'd0 || key_pressed !== 1'b0) begin
      errors++; $display("FAIL idle_frame: got %h/%b want 0000/0", onehot, key_pressed);
    end
  endtask

  task automatic test_single_press();
    logic [15:0] oh; logic kp; int g;
    for (int f = 1; f <= 4; f++) begin
      run_frame(16'h0040, oh, kp, g);
      model_frame(16'h0040);
      checks++;
      if (oh !== m_onehot || kp !== m_strobe || g !== 0) begin
        errors++;
        $display("FAIL single_press frame %0d: got %h kp=%b glitch=%0d want %h kp=%b glitch=0",
                 f, oh, kp, g, m_onehot, m_strobe);
      end
      if (f == 3) begin
        checks++;
        if (oh !== 16'h0040 || kp !== 1'b1) begin
          errors++; $display("FAIL single_press_value: got %h kp=%b want 0040 kp=1", oh, kp);
        end
      end
    end
  endtask

  task automatic test_hold_release();
    logic [15:0] oh; logic kp; int g; int strobes;
    strobes = 0;
    for (int f = 1; f <= 10; f++) begin
      run_frame(16'h8000, oh, kp, g);
      model_frame(16'h8000);
      if (kp === 1'b1) strobes++;
      checks++;
      if (oh !== m_onehot || kp !== m_strobe || g !== 0) begin
        errors++;
        $display("FAIL hold frame %0d: got %h kp=%b glitch=%0d want %h kp=%b glitch=0",
                 f, oh, kp, g, m_onehot, m_strobe);
      end
    end
    checks++;
    if (oh !== 16'h8000 || strobes !== 1) begin
      errors++; $display("FAIL hold_value: got %h strobes=%0d want 8000 strobes=1", oh, strobes);
    end
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0000, oh, kp, g);
      model_frame(16'h0000);
      checks++;
      if (oh !== m_onehot || kp !== 1'b0 || g !== 0) begin
        errors++;
        $display("FAIL release frame %0d: got %h kp=%b glitch=%0d want %h kp=0 glitch=0",
                 f, oh, kp, g, m_onehot);
      end
    end
    checks++;
    if (oh !== 16'h0000) begin
      errors++; $display("FAIL release_value: got %h want 0000", oh);
    end
  endtask

  task automatic test_ghosting();
    logic [15:0] oh; logic kp; int g;
    for (int f = 1; f <= 4; f++) begin
      run_frame(16'h0201, oh, kp, g);
      model_frame(16'h0201);
      checks++;
      if (oh !== 16'h0000 || kp !== 1'b0 || g !== 0) begin
        errors++;
        $display("FAIL ghost frame %0d: got %h kp=%b glitch=%0d want 0000 kp=0 glitch=0",
                 f, oh, kp, g);
      end
    end
  endtask

  task automatic test_bounce();
    logic [15:0] oh; logic kp; int g; logic [15:0] k;
    for (int f = 0; f < 6; f++) begin
      k = (f % 2 == 0) ? 16'h0008 : 16'h0000;
      run_frame(k, oh, kp, g);
      model_frame(k);
      checks++;
      if (oh !== 16'h0000 || kp !== 1'b0 || g !== 0) begin
        errors++;
        $display("FAIL bounce frame %0d: got %h kp=%b glitch=%0d want 0000 kp=0 glitch=0",
                 f, oh, kp, g);
      end
    end
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0008, oh, kp, g);
      model_frame(16'h0008);
      checks++;
      if (oh !== m_onehot || kp !== m_strobe || g !== 0) begin
        errors++;
        $display("FAIL bounce_hold frame %0d: got %h kp=%b glitch=%0d want %h kp=%b glitch=0",
                 f, oh, kp, g, m_onehot, m_strobe);
      end
    end
    checks++;
    if (oh !== 16'h0008) begin
      errors++; $display("FAIL bounce_value: got %h want 0008", oh);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] oh; logic kp; int g;
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0020, oh, kp, g);
      model_frame(16'h0020);
    end
    checks++;
    if (oh !== 16'h0020) begin
      errors++; $display("FAIL pre_reset_value: got %h want 0020", oh);
    end
    for (int f = 1; f <= 2; f++) begin
      run_frame(16'h0010, oh, kp, g);
      model_frame(16'h0010);
      checks++;
      if (oh !== 16'h0020 || kp !== 1'b0 || g !== 0) begin
        errors++;
        $display("FAIL pre_reset frame %0d: got %h kp=%b glitch=%0d want 0020 kp=0 glitch=0",
                 f, oh, kp, g);
      end
    end
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (onehot !== 16'h0000 || col !== 4'b1110 || key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got onehot=%h col=%b kp=%b want 0000/1110/0",
               onehot, col, key_pressed);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int f = 1; f <= 3; f++) begin
      run_frame(16'h0010, oh, kp, g);
      model_frame(16'h0010);
      checks++;
      if (oh !== m_onehot || kp !== m_strobe || g !== 0) begin
        errors++;
        $display("FAIL post_reset frame %0d: got %h kp=%b glitch=%0d want %h kp=%b glitch=0",
                 f, oh, kp, g, m_onehot, m_strobe);
      end
    end
    checks++;
    if (oh !== 16'h0010 || kp !== 1'b1) begin
      errors++; $display("FAIL post_reset_value: got %h kp=%b want 0010 kp=1", oh, kp);
    end
  endtask

  task automatic test_random();
    logic [15:0] oh; logic kp; int g; logic [15:0] k; int sel;
    k = keys;
    for (int f = 1; f <= 40; f++) begin
      sel = $urandom_range(0, 9);
      if (sel == 5 || sel == 6)
        k = 16'h0001 << $urandom_range(0, 15);
      else if (sel == 7)
        k = 16'h0000;
      else if (sel == 8)
        k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      else if (sel == 9)
        k = 16'($urandom);
      run_frame(k, oh, kp, g);
      model_frame(k);
      checks++;
      if (oh !== m_onehot || kp !== m_strobe || g !== 0) begin
        errors++;
        $display("FAIL random frame %0d keys=%h: got %h kp=%b glitch=%0d want %h kp=%b glitch=0",
                 f, k, oh, kp, g, m_onehot, m_strobe);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'd0;
    rst_n  = 1'b0;
    model_reset();
    test_reset();
    test_single_press();
    test_hold_release();
    test_ghosting();
    test_bounce();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
